// File: rtl/alu_seg_display.sv
// alu_seg_display: captures a 4-bit ALU result with its flags and op code and shows it on a
// 4-digit time-multiplexed 7-segment display.
//   digit0 = result (magnitude for signed ops), dp lit on carry-out
//   digit1 = '-' for a negative signed result, else blank
//   digit2 = blank
//   digit3 = op code in hex
// Signed overflow blinks the whole display with a period of 2*BLINK_FRAMES scan frames.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   res_valid  1-cycle strobe qualifying res/func/overflow/cout
//   res        ALU result
//   func       ALU op code
//   overflow   ALU signed overflow
//   cout       ALU carry-out
//   an         digit enables, active-low
//   seg        segments, active-low, {dp,g,f,e,d,c,b,a}
module alu_seg_display #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       res_valid,
  input  logic [3:0] res,
  input  logic [2:0] func,
  input  logic       overflow,
  input  logic       cout,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FW = $clog2(BLINK_FRAMES + 1);

  localparam logic [6:0] SegMinus = 7'b0111111;
  localparam logic [6:0] SegBlank = 7'h7F;

  logic [3:0]    res_q;
  logic [2:0]    func_q;
  logic          ovf_q;
  logic          cout_q;
  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;
  logic [FW-1:0] frame_q;
  logic          phase_q;  // 1 = ON half of the blink period
  logic [3:0]    an_q;
  logic [7:0]    seg_q;

  logic          tc;
  logic          wrap;
  logic          frame_hit;
  logic [FW-1:0] frame_inc;
  logic          phase_scan;
  logic [1:0]    idx_next;
  logic [3:0]    mag;
  logic [3:0]    dig0_val;
  logic          is_signed;
  logic [3:0]    an_next;
  logic [7:0]    seg_next;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    tc        = (presc_q == PW'(SCAN_DIV - 1));
    idx_next  = idx_q + 2'd1;
    wrap      = tc && (idx_q == 2'd3);
    frame_inc = frame_q + FW'(1);
    frame_hit = wrap && (frame_inc == FW'(BLINK_FRAMES));
    // Use the phase that takes effect at this wrap so dark periods align with frame starts.
    phase_scan = frame_hit ? ~phase_q : phase_q;

    is_signed = (func_q[2:1] == 2'b00);
    // Two's-complement negate in 4 bits; -8 maps to 4'b1000 which still reads as 8.
    mag = res_q[3] ? (~res_q + 4'd1) : res_q;

    if (is_signed) begin
      dig0_val = mag;
    end else if (func_q[2:1] == 2'b11) begin
      dig0_val = {3'b000, res_q[0]};
    end else begin
      dig0_val = res_q;
    end

    unique case (idx_next)
      2'd0:    seg_next = {~cout_q, hex7(dig0_val)};
      2'd1:    seg_next = {1'b1, (is_signed && res_q[3]) ? SegMinus : SegBlank};
      2'd2:    seg_next = 8'hFF;
      default: seg_next = {1'b1, hex7({1'b0, func_q})};
    endcase

    an_next = (ovf_q && !phase_scan) ? 4'b1111 : ~(4'b0001 << idx_next);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q   <= '0;
      func_q  <= '0;
      ovf_q   <= 1'b0;
      cout_q  <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      phase_q <= 1'b1;
      an_q    <= 4'b1111;
      seg_q   <= 8'hFF;
    end else begin
      presc_q <= tc ? '0 : presc_q + PW'(1);

      if (tc) begin
        idx_q <= idx_next;
        an_q  <= an_next;
        seg_q <= seg_next;
      end

      // Capture overrides the blink bookkeeping; the scan above still used the old values.
      if (res_valid) begin
        res_q   <= res;
        func_q  <= func;
        ovf_q   <= overflow;
        cout_q  <= cout;
        frame_q <= '0;
        phase_q <= 1'b1;
      end else if (wrap) begin
        frame_q <= frame_hit ? '0 : frame_inc;
        phase_q <= phase_scan;
      end
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_alu_seg_display.sv
// Testbench for alu_seg_display with SCAN_DIV=4, BLINK_FRAMES=2. A behavioural model counts
// clocks since reset and scan wraps since the last capture, pushes the expected {an,seg} for
// every scan update into a queue, and the checker pops and compares just after the edge.
module tb_alu_seg_display;

  localparam int unsigned SD = 4;
  localparam int unsigned BF = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       res_valid;
  logic [3:0] res;
  logic [2:0] func;
  logic       overflow;
  logic       cout;
  logic [3:0] an;
  logic [7:0] seg;

  always #5 clk = ~clk;

  alu_seg_display #(
    .SCAN_DIV    (SD),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .res_valid(res_valid),
    .res      (res),
    .func     (func),
    .overflow (overflow),
    .cout     (cout),
    .an       (an),
    .seg      (seg)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [11:0] exp_q[$];
  logic [6:0]  hex_tab[16];

  // Model state
  int         t;
  int         wraps;
  logic [3:0] m_res;
  logic [2:0] m_func;
  logic       m_ovf;
  logic       m_cout;

  task automatic check_val(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got an=%b seg=%h, want an=%b seg=%h",
               tag, obs[11:8], obs[7:0], exp[11:8], exp[7:0]);
    end
  endtask

  function automatic logic [11:0] model_out(input int d);
    logic [7:0] s;
    logic [3:0] a;
    logic [3:0] m;
    int         sv;
    bit         off;
    s = 8'hFF;
    m = 4'h0;
    case (d)
      0: begin
        if (m_func < 3'd2) begin
          sv = m_res[3] ? int'(m_res) - 16 : int'(m_res);
          m  = 4'((sv < 0) ? -sv : sv);
        end else if (m_func < 3'd6) begin
          m = m_res;
        end else begin
          m = {3'b000, m_res[0]};
        end
        s = {~m_cout, hex_tab[m]};
      end
      1: s = (m_func < 3'd2 && m_res[3]) ? 8'hBF : 8'hFF;
      2: s = 8'hFF;
      default: s = {1'b1, hex_tab[{1'b0, m_func}]};
    endcase
    off = m_ovf && (((wraps / BF) % 2) == 1);
    a = 4'hF;
    if (!off) a[d] = 1'b0;
    return {a, s};
  endfunction

  task automatic model_reset();
    t      = 0;
    wraps  = 0;
    m_res  = '0;
    m_func = '0;
    m_ovf  = 1'b0;
    m_cout = 1'b0;
    exp_q.delete();
  endtask

  task automatic step(input logic v, input logic [3:0] r, input logic [2:0] f,
                      input logic o, input logic c);
    logic [11:0] e;
    int          d;
    @(negedge clk);
    res_valid = v;
    res       = r;
    func      = f;
    overflow  = o;
    cout      = c;
    @(posedge clk);
    t++;
    if (t % SD == 0) begin
      d = (t / SD) % 4;
      if (d == 0) wraps++;
      exp_q.push_back(model_out(d));
    end
    if (v) begin
      m_res  = r;
      m_func = f;
      m_ovf  = o;
      m_cout = c;
      wraps  = 0;
    end
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val($sformatf("scan_t%0d", t), {an, seg}, e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'h0, 3'h0, 1'b0, 1'b0);
  endtask

  task automatic capture(input logic [3:0] r, input logic [2:0] f, input logic o, input logic c);
    step(1'b1, r, f, o, c);
  endtask

  task automatic reset_and_check(input string tag);
    logic [11:0] e;
    rst = 1'b1;
    res_valid = 1'b0;
    #1;
    model_reset();
    exp_q.push_back({4'b1111, 8'hFF});
    e = exp_q.pop_front();
    check_val(tag, {an, seg}, e);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst       = 1'b1;
    res_valid = 1'b0;
    res       = '0;
    func      = '0;
    overflow  = 1'b0;
    cout      = 1'b0;

    reset_and_check("reset");
    idle(20);

    capture(4'b1101, 3'b001, 1'b0, 1'b1);  // -3 with carry
    idle(16);
    capture(4'b1000, 3'b000, 1'b0, 1'b0);  // -8
    idle(16);
    capture(4'hA, 3'b010, 1'b0, 1'b0);
    idle(16);
    capture(4'h7, 3'b110, 1'b0, 1'b1);     // logic op shows res[0]
    idle(16);

    capture(4'h5, 3'b011, 1'b1, 1'b0);     // overflow -> blink
    idle(80);
    idle(40);
    capture(4'h9, 3'b100, 1'b1, 1'b1);     // recapture, display relights
    idle(70);

    // Capture on the prescaler terminal-count edge.
    while ((t + 1) % SD != 0) idle(1);
    capture(4'h3, 3'b101, 1'b0, 1'b0);
    idle(12);

    // Asynchronous reset mid-scan.
    idle(2);
    #2;
    reset_and_check("async_reset");
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
